// File: rtl/svfloat_pkg.sv
`default_nettype none
// ============================================================================
// Module : svfloat (package)
// Float typedefs, divider state encoding and shared sizing helpers.
// Rev    : 1.0
// ============================================================================
package svfloat;

    typedef struct packed {
        logic        s;
        logic [7:0]  e;
        logic [22:0] m;
    } float32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Quotient width shared by the divider and the downstream packer.
    function automatic int div_qw(input int man_width);
        return man_width + 3;
    endfunction

endpackage
`default_nettype wire

// File: rtl/svfloat_msb.sv
`default_nettype none
// ============================================================================
// Module : svfloat_msb
// Index of the most significant set bit (0 when the input is zero).
// Rev    : 1.0
// ============================================================================
module svfloat_msb #(
    parameter  int W  = 23,
    localparam int IW = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]  i_v,
    output logic [IW-1:0] o_idx
);

    always_comb begin
        o_idx = '0;
        for (int i = 0; i < W; i++) begin
            if (i_v[i]) o_idx = IW'(i);
        end
    end

endmodule
`default_nettype wire

// File: rtl/svfloat_unpacker.sv
`default_nettype none
// ============================================================================
// Module : svfloat_unpacker
// Classifies one operand and returns its true exponent and normalised mantissa.
// Rev    : 1.0
// ============================================================================
module svfloat_unpacker #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic [EXP_W-1:0]        i_e,
    input  logic [MAN_W-1:0]        i_m,
    output logic                    o_zero,
    output logic                    o_inf,
    output logic                    o_nan,
    output logic signed [EXP_W+1:0] o_texp,
    output logic [MAN_W:0]          o_man
);

    localparam int BIAS = 2 ** (EXP_W - 1) - 1;
    localparam int EW   = EXP_W + 2;
    localparam int IW   = (MAN_W > 1) ? $clog2(MAN_W) : 1;

    logic [IW-1:0] w_msb;
    logic          w_emax;
    logic          w_emin;
    logic          w_mzero;

    svfloat_msb #(.W(MAN_W)) u_msb (
        .i_v   (i_m),
        .o_idx (w_msb)
    );

    always_comb begin
        w_emax  = &i_e;
        w_emin  = ~|i_e;
        w_mzero = ~|i_m;
        o_zero  = w_emin & w_mzero;
        o_inf   = w_emax & w_mzero;
        o_nan   = w_emax & ~w_mzero;
        if (w_emin) begin
            // Denormal: shift the leading one into the hidden-bit position.
            o_texp = EW'(1 - BIAS - MAN_W + int'(w_msb));
            o_man  = (MAN_W + 1)'({1'b0, i_m} << (MAN_W - int'(w_msb)));
        end else begin
            o_texp = EW'(int'(i_e) - BIAS);
            o_man  = {1'b1, i_m};
        end
    end

endmodule
`default_nettype wire

// File: rtl/svfloat_div_iter.sv
`default_nettype none
// ============================================================================
// Module : svfloat_div_iter
// Iterative restoring FP divider, one quotient bit per clock, unrounded output.
// Rev    : 1.0
// ============================================================================
module svfloat_div_iter
    import svfloat::*;
#(
    parameter type float = svfloat::float32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  float                             in_a,
    input  float                             in_b,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             out_is_inf,
    output logic                             out_is_nan,
    output logic                             out_is_zero,
    output logic                             out_sign,
    output logic signed [$bits(in_a.e)+1:0]  out_exp,
    output logic [div_qw($bits(in_a.m))-1:0] out_man
);

    localparam int EXP_W = $bits(in_a.e);
    localparam int MAN_W = $bits(in_a.m);
    localparam int EW    = EXP_W + 2;
    localparam int QW    = div_qw(MAN_W);
    localparam int OFRAC = MAN_W + 2;
    localparam int RW    = OFRAC;  // partial remainder width equals the fraction width
    localparam int CW    = $clog2(QW + 1);

    div_state_t           r_state;
    logic [CW-1:0]        r_cnt;
    logic [RW-1:0]        r_rem;
    logic [MAN_W:0]       r_mb;
    logic [QW-2:0]        r_q;

    logic                 w_a_zero, w_a_inf, w_a_nan;
    logic                 w_b_zero, w_b_inf, w_b_nan;
    logic signed [EW-1:0] w_ea, w_eb;
    logic [MAN_W:0]       w_ma, w_mb;
    logic                 w_nan, w_inf, w_zero;
    logic [RW:0]          w_diff;
    logic                 w_ge;
    logic [RW-1:0]        w_rem_next;
    logic                 w_sticky;

    svfloat_unpacker #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_a (
        .i_e    (in_a.e),
        .i_m    (in_a.m),
        .o_zero (w_a_zero),
        .o_inf  (w_a_inf),
        .o_nan  (w_a_nan),
        .o_texp (w_ea),
        .o_man  (w_ma)
    );

    svfloat_unpacker #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_b (
        .i_e    (in_b.e),
        .i_m    (in_b.m),
        .o_zero (w_b_zero),
        .o_inf  (w_b_inf),
        .o_nan  (w_b_nan),
        .o_texp (w_eb),
        .o_man  (w_mb)
    );

    always_comb begin
        w_nan      = w_a_nan | w_b_nan | (w_a_zero & w_b_zero) | (w_a_inf & w_b_inf);
        w_inf      = ~w_nan & (w_a_inf | w_b_zero);
        w_zero     = ~w_nan & ~w_inf & (w_a_zero | w_b_inf);
        w_diff     = {1'b0, r_rem} - {2'b00, r_mb};
        w_ge       = ~w_diff[RW];
        w_rem_next = w_ge ? w_diff[RW-1:0] : r_rem;
        w_sticky   = |w_rem_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_rem       <= '0;
            r_mb        <= '0;
            r_q         <= '0;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            out_is_inf  <= 1'b0;
            out_is_nan  <= 1'b0;
            out_is_zero <= 1'b0;
            out_sign    <= 1'b0;
            out_exp     <= '0;
            out_man     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_state     <= DIV;
                        in_ready    <= 1'b0;
                        r_cnt       <= '0;
                        r_rem       <= {1'b0, w_ma};
                        r_mb        <= w_mb;
                        r_q         <= '0;
                        out_is_nan  <= w_nan;
                        out_is_inf  <= w_inf;
                        out_is_zero <= w_zero;
                        out_sign    <= w_nan ? 1'b0 : (in_a.s ^ in_b.s);
                        out_exp     <= (w_nan | w_inf | w_zero) ? '0 : (w_ea - w_eb);
                        out_man     <= '0;
                    end
                end
                DIV: begin
                    if (out_is_nan | out_is_inf | out_is_zero) begin
                        // Special result already latched; just publish it.
                        r_state   <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        r_rem <= {w_rem_next[RW-2:0], 1'b0};
                        r_q   <= {r_q[QW-3:0], w_ge};
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == CW'(QW - 1)) begin
                            r_state   <= DONE;
                            out_valid <= 1'b1;
                            out_man   <= {r_q, w_ge | w_sticky};
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state   <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/svfloat_div_iter.md
Name: svfloat_div_iter

Overview:
- Iterative floating-point divider, one quotient bit per clock (restoring division).
- Computes a/b and emits an unrounded sign/exponent/mantissa triple plus inf/nan/zero overrides.
- Sits directly upstream of svfloat_packer, which normalises and packs the result.
- Valid/ready handshake on input and output.

Parameters:
- float, svfloat::float32, floating-point type for both operands; exponent/mantissa widths derived via $bits.
- Derived localparams (not overridable):
  - QW = man_width+3, quotient width.
  - OFRAC = man_width+2, fractional bits of out_man; the packer is instantiated with frac=OFRAC, width=QW, ewidth=exp_width+2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  operands present
- in_ready  out  1  block can accept operands
- in_a  in  float  dividend
- in_b  in  float  divisor
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- out_is_inf  out  1  result is infinity
- out_is_nan  out  1  result is NaN
- out_is_zero  out  1  result is zero
- out_sign  out  1  result sign
- out_exp  out  exp_width+2 signed  unbiased exponent
- out_man  out  QW  quotient; value = out_man * 2^(out_exp - OFRAC)

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- Reset values: state IDLE, in_ready=1, out_valid=0, all other outputs 0.
- States: IDLE, DIV, DONE.
  - in_ready = (state==IDLE); accept on in_valid & in_ready.
  - In DONE, outputs are held stable until out_valid & out_ready, then return to IDLE.
  - No overlap: next accept is at earliest the cycle after the output handshake.
- Accept edge (edge 0) loads registers:
  - sign = a.s ^ b.s.
  - Operands unpacked: hidden bit restored; denormals pre-normalised so that ma, mb ∈ [2^man_width, 2^(man_width+1)), with exponents adjusted (ea, eb true exponents, denormal down to min_texp - man_width).
  - exp = ea - eb, computed at exp_width+2 signed; must not overflow for float32 (range ±276).
- Special cases are decided at the accept edge. The state goes directly to DONE and out_valid is high after edge 1.
  - NaN: a or b NaN, 0/0, or inf/inf. Sign forced 0, man 0.
  - Inf: a inf with b finite, or b zero with a finite nonzero.
  - Zero: a zero with b nonzero, or b inf with a finite.
  - Exactly one of is_inf/is_nan/is_zero is high for special results; all three are low otherwise.
- Normal path:
  - Restoring division computes q = floor(ma * 2^(QW-1) / mb), MSB first, one bit per edge on edges 1..QW.
  - Partial remainder is man_width+2 bits.
  - At edge QW: out_man = q | (remainder != 0), i.e. sticky in LSB; out_valid is high after edge QW.
  - q ∈ [2^(QW-2), 2^QW), so the MSB is at QW-1 or QW-2; the packer handles normalisation, overflow to inf and denormal.
  - No rounding is done here; truncation plus sticky is the contract.
- Iteration counter: $clog2(QW+1) bits, counts 0..QW-1.
- rst asserted in any state, including mid-DIV or DONE with out_ready low: next cycle is IDLE, the in-flight result is discarded and out_valid=0.
- in_valid while busy is ignored; operands are not sampled.
- out_ready while not out_valid has no effect.

Decomposition:
- svfloat package: float typedefs (already present), plus the helper function svfloat::div_qw(man_width), so the packer instantiation and this block agree on QW/OFRAC.
- Sub-module svfloat_unpacker (combinational): classifies one operand (zero/inf/nan/denormal), restores the hidden bit, normalises denormals via svfloat_msb, and outputs the true exponent and mantissa. It is instantiated twice.
- Divider datapath and FSM live in this module.

Test Plan:
- 6.0/2.0 (0x40C00000/0x40000000) -> out_valid after edge 26, sign 0, out_exp=1, out_man=0x3000000; flags low; via packer -> 0x40400000.
- 1.0/3.0 (0x3F800000/0x40400000) -> out_exp=-1, out_man=0x1555555 (sticky set); via packer -> 0x3EAAAAAA.
- Specials: -1.0/0.0 -> is_inf=1, sign 1, out_valid after edge 1. 0.0/0.0 and inf/inf -> is_nan=1. 0.0/5.0 and 5.0/inf -> is_zero=1.
- Denormal: 0x00000001/0x3F800000 -> out_exp=-149, out_man=0x2000000; via packer -> 0x00000001.
- Back-pressure: hold out_ready=0 for 10 cycles after out_valid -> outputs stable, in_ready=0, new in_valid ignored. Then out_ready=1 -> IDLE next cycle and the new operand is accepted.
- Reset mid-DIV (edge 10) -> next cycle IDLE, in_ready=1, out_valid=0; the following 6.0/2.0 completes correctly.
